pc_predict_unit: RTL and testbench

- Parametrised fetch-side next-PC generator. Holds the architectural fetch PC register and predicts the next PC through a direct-mapped branch target buffer (BTB) with 2-bit counters.
- Resolves branch and jump outcomes from the execute stage and issues a one-cycle redirect on mispredict.
- Replaces the purely combinational PC selection path. Sits between fetch and the execute/branch-resolve logic.

---
 rtl/pc_predict_unit_pkg.sv | 19 +
 rtl/pc_predict_unit_if.sv | 37 +++
 rtl/pc_predict_unit_btb.sv | 80 ++++++++
 rtl/pc_predict_unit.sv | 92 +++++++++
 tb/tb_pc_predict_unit.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pc_predict_unit_pkg.sv
// Shared types for the fetch-side next-PC predictor: branch condition codes
// and the 2-bit BTB counter encodings.
package pc_pkg;

  typedef enum logic [1:0] {
    COND_Z   = 2'b00,
    COND_NZ  = 2'b01,
    COND_LTZ = 2'b10,
    COND_GEZ = 2'b11
  } cond_e;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

endpackage

// File: rtl/pc_predict_unit_if.sv
// Fetch/execute-side signal bundle of the next-PC predictor; master drives
// stall/halt and the resolving instruction, slave is the predictor itself.
interface pc_predict_unit_if
  import pc_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             stall;
  logic             halt;
  logic [WIDTH-1:0] pc_f;
  logic [WIDTH-1:0] pred_next_f;
  logic             ex_valid;
  logic [WIDTH-1:0] ex_pc;
  logic             ex_is_branch;
  logic             ex_is_jump;
  logic             ex_jump_reg;
  cond_e            ex_cond;
  logic             ex_zero;
  logic             ex_ltz;
  logic [WIDTH-1:0] ex_imm;
  logic [WIDTH-1:0] ex_reg;
  logic [WIDTH-1:0] ex_pred_next;
  logic             redirect;
  logic             err;

  modport master (
    output stall, halt, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_jump_reg,
           ex_cond, ex_zero, ex_ltz, ex_imm, ex_reg, ex_pred_next,
    input  pc_f, pred_next_f, redirect, err
  );

  modport slave (
    input  stall, halt, ex_valid, ex_pc, ex_is_branch, ex_is_jump, ex_jump_reg,
           ex_cond, ex_zero, ex_ltz, ex_imm, ex_reg, ex_pred_next,
    output pc_f, pred_next_f, redirect, err
  );
endinterface

// File: rtl/pc_predict_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup by fetch PC,
// synchronous allocate/update by resolved PC with saturating 2-bit counters.
module btb
  import pc_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int BTB_ENTRIES = 8,
  parameter int INSTR_BYTES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] rd_pc_i,
  output logic             rd_taken_o,
  output logic [WIDTH-1:0] rd_tgt_o,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_pc_i,
  input  logic [WIDTH-1:0] wr_tgt_i,
  input  logic             wr_jmp_i,
  input  logic             wr_taken_i
);
  localparam int OFF_W = $clog2(INSTR_BYTES);
  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = WIDTH - OFF_W - IDX_W;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] tgt;
    logic             jmp;
    ctr_e             ctr;
  } btb_entry_t;

  btb_entry_t       entry_q [BTB_ENTRIES];
  btb_entry_t       rd_e;
  btb_entry_t       wr_d;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] rd_tag, wr_tag;
  logic             rd_hit, wr_hit;
  ctr_e             wr_old_ctr;

  function automatic ctr_e ctr_step(input ctr_e c, input logic up);
    if (up) return (c == ST)  ? ST  : ctr_e'(2'(c + 2'd1));
    else    return (c == SNT) ? SNT : ctr_e'(2'(c - 2'd1));
  endfunction

  // Shifting whole PCs keeps the instruction-offset bits out of index and tag.
  assign rd_idx = IDX_W'(rd_pc_i >> OFF_W);
  assign rd_tag = TAG_W'(rd_pc_i >> (OFF_W + IDX_W));
  assign wr_idx = IDX_W'(wr_pc_i >> OFF_W);
  assign wr_tag = TAG_W'(wr_pc_i >> (OFF_W + IDX_W));

  assign rd_e       = entry_q[rd_idx];
  assign rd_hit     = rd_e.valid && (rd_e.tag == rd_tag);
  assign rd_taken_o = rd_hit && (rd_e.jmp || rd_e.ctr == WT || rd_e.ctr == ST);
  assign rd_tgt_o   = rd_e.tgt;

  assign wr_hit     = entry_q[wr_idx].valid && (entry_q[wr_idx].tag == wr_tag);
  assign wr_old_ctr = entry_q[wr_idx].ctr;

  always_comb begin
    // NOTE: every field gets a value on every path, so no latch is inferred.
    wr_d.valid = 1'b1;
    wr_d.tag   = wr_tag;
    wr_d.tgt   = wr_tgt_i;
    wr_d.jmp   = wr_jmp_i;
    wr_d.ctr   = wr_taken_i ? WT : WNT;
    if (wr_hit) wr_d.ctr = ctr_step(wr_old_ctr, wr_taken_i);
  end

  // NOTE: only the valid bits are reset; tag/target/counter are don't-care
  // until an entry is allocated, so the storage needs no reset fan-out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BTB_ENTRIES; i++) entry_q[i].valid <= 1'b0;
    end else if (wr_en_i) begin
      entry_q[wr_idx] <= wr_d;
    end
  end

endmodule

// File: rtl/pc_predict_unit.sv
// Fetch PC register with BTB-based next-PC prediction, execute-stage branch
// resolution, one-cycle mispredict redirect and sticky target-overflow flag.
module pc_predict_unit
  import pc_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               BTB_ENTRIES = 8,
  parameter int               INSTR_BYTES = 2,
  parameter logic [WIDTH-1:0] RESET_PC    = '0
) (
  input logic              clk,
  input logic              rst,
  pc_predict_unit_if.slave bus
);
  localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);

  logic [WIDTH-1:0] pc_q, pc_d;
  logic             err_q, err_d;
  logic             cond_met, taken, is_ctrl, tgt_ovf, redirect;
  logic [WIDTH-1:0] seq_pc, tgt_base, target, actual;
  logic             btb_taken;
  logic [WIDTH-1:0] btb_tgt, pred_next;

  btb #(
    .WIDTH      (WIDTH),
    .BTB_ENTRIES(BTB_ENTRIES),
    .INSTR_BYTES(INSTR_BYTES)
  ) u_btb (
    .clk       (clk),
    .rst       (rst),
    .rd_pc_i   (pc_q),
    .rd_taken_o(btb_taken),
    .rd_tgt_o  (btb_tgt),
    .wr_en_i   (bus.ex_valid && is_ctrl),
    .wr_pc_i   (bus.ex_pc),
    .wr_tgt_i  (target),
    .wr_jmp_i  (bus.ex_is_jump),
    .wr_taken_i(taken)
  );

  assign pred_next = btb_taken ? btb_tgt : pc_q + STEP;

  always_comb begin
    cond_met = 1'b0;
    case (bus.ex_cond)
      COND_Z:   cond_met =  bus.ex_zero;
      COND_NZ:  cond_met = ~bus.ex_zero;
      COND_LTZ: cond_met =  bus.ex_ltz;
      COND_GEZ: cond_met = ~bus.ex_ltz;
      default:  cond_met = 1'b0;
    endcase
  end

  assign is_ctrl  = bus.ex_is_branch || bus.ex_is_jump;
  assign taken    = bus.ex_is_jump || (bus.ex_is_branch && cond_met);
  assign seq_pc   = bus.ex_pc + STEP;
  assign tgt_base = bus.ex_jump_reg ? bus.ex_reg : seq_pc;
  assign target   = tgt_base + bus.ex_imm;
  assign actual   = taken ? target : seq_pc;
  assign tgt_ovf  = (tgt_base[WIDTH-1] == bus.ex_imm[WIDTH-1]) &&
                    (target[WIDTH-1] != tgt_base[WIDTH-1]);

  // Any resolved instruction whose carried prediction is wrong redirects,
  // control or not; reset masks it.
  assign redirect = !rst && bus.ex_valid && (actual != bus.ex_pred_next);

  always_comb begin
    pc_d = pred_next;
    if (redirect)                   pc_d = actual;
    else if (bus.halt || bus.stall) pc_d = pc_q;
  end

  assign err_d = err_q || (bus.ex_valid && is_ctrl && tgt_ovf);

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q  <= RESET_PC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  assign bus.pc_f        = pc_q;
  assign bus.pred_next_f = pred_next;
  assign bus.redirect    = redirect;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_pc_predict_unit.sv
// Directed test of pc_predict_unit (WIDTH=16, 8 BTB entries, 2-byte step)
// with hand-computed expected PCs, predictions, redirects and error flag.
module tb_pc_predict_unit;
  import pc_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  pc_predict_unit_if #(.WIDTH(16)) bus ();

  pc_predict_unit #(
    .WIDTH      (16),
    .BTB_ENTRIES(8),
    .INSTR_BYTES(2),
    .RESET_PC   (16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ex_valid     = 1'b0;
    bus.ex_pc        = '0;
    bus.ex_is_branch = 1'b0;
    bus.ex_is_jump   = 1'b0;
    bus.ex_jump_reg  = 1'b0;
    bus.ex_cond      = COND_Z;
    bus.ex_zero      = 1'b0;
    bus.ex_ltz       = 1'b0;
    bus.ex_imm       = '0;
    bus.ex_reg       = '0;
    bus.ex_pred_next = '0;
  endtask

  // Present one resolving instruction and let combinational outputs settle.
  task automatic drive(input logic [15:0] pc, input logic br, input logic jmp,
                       input logic jr, input cond_e cond, input logic zero,
                       input logic ltz, input logic [15:0] imm,
                       input logic [15:0] rg, input logic [15:0] pred);
    bus.ex_valid     = 1'b1;
    bus.ex_pc        = pc;
    bus.ex_is_branch = br;
    bus.ex_is_jump   = jmp;
    bus.ex_jump_reg  = jr;
    bus.ex_cond      = cond;
    bus.ex_zero      = zero;
    bus.ex_ltz       = ltz;
    bus.ex_imm       = imm;
    bus.ex_reg       = rg;
    bus.ex_pred_next = pred;
    #1;
  endtask

  // Steer fetch to dest through a mispredicted non-control instruction.
  task automatic goto(input logic [15:0] dest);
    drive(dest - 16'h2, 1'b0, 1'b0, 1'b0, COND_Z, 1'b0, 1'b0, 16'h0, 16'h0,
          dest + 16'h0100);
    tick();
    idle();
    #1;
    check("goto_pc", bus.pc_f, dest);
  endtask

  initial begin
    rst       = 1'b1;
    bus.stall = 1'b0;
    bus.halt  = 1'b0;
    idle();
    tick();
    drive(16'h0020, 1'b0, 1'b0, 1'b0, COND_Z, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    check("rst_redirect_masked", {15'h0, bus.redirect}, 16'h0);
    tick();
    rst = 1'b0;
    idle();
    #1;
    check("rst_pc", bus.pc_f, 16'h0000);
    check("rst_redirect", {15'h0, bus.redirect}, 16'h0);
    check("rst_err", {15'h0, bus.err}, 16'h0);
    check("rst_pred", bus.pred_next_f, 16'h0002);
    tick();
    check("seq_pc1", bus.pc_f, 16'h0002);
    tick();
    check("seq_pc2", bus.pc_f, 16'h0004);

    bus.stall = 1'b1;
    #1;
    check("stall_c1", bus.pc_f, 16'h0004);
    tick();
    check("stall_c2", bus.pc_f, 16'h0004);
    tick();
    check("stall_c3", bus.pc_f, 16'h0004);
    drive(16'h0000, 1'b0, 1'b1, 1'b0, COND_Z, 1'b0, 1'b0, 16'h0010, 16'h0, 16'h0002);
    check("stall_jump_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    bus.stall = 1'b0;
    idle();
    #1;
    check("stall_jump_pc", bus.pc_f, 16'h0012);

    drive(16'h0010, 1'b1, 1'b0, 1'b0, COND_Z, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h0012);
    check("cold_br_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    idle();
    #1;
    check("cold_br_pc", bus.pc_f, 16'h0032);
    goto(16'h0010);
    check("btb_hit_pred", bus.pred_next_f, 16'h0032);

    drive(16'h0010, 1'b1, 1'b0, 1'b0, COND_NZ, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h0012);
    check("nt_correct_redirect", {15'h0, bus.redirect}, 16'h0);
    tick();
    idle();
    #1;
    check("nt_follow_pred_pc", bus.pc_f, 16'h0032);
    goto(16'h0010);
    check("decayed_pred", bus.pred_next_f, 16'h0012);

    drive(16'h0010, 1'b1, 1'b0, 1'b0, COND_Z, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h0012);
    check("same_idx_old_pred", bus.pred_next_f, 16'h0012);
    check("retaken_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    idle();
    #1;
    check("retaken_pc", bus.pc_f, 16'h0032);
    goto(16'h0010);
    check("reinc_pred", bus.pred_next_f, 16'h0032);

    drive(16'h0100, 1'b0, 1'b1, 1'b1, COND_Z, 1'b0, 1'b0, 16'h0004, 16'h1000, 16'h0102);
    check("jr_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    idle();
    #1;
    check("jr_pc", bus.pc_f, 16'h1004);
    goto(16'h0100);
    check("jr_btb_pred", bus.pred_next_f, 16'h1004);

    drive(16'hFFFE, 1'b0, 1'b0, 1'b0, COND_Z, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0000);
    check("seq_wrap_redirect", {15'h0, bus.redirect}, 16'h0);
    tick();
    idle();
    #1;
    check("seq_wrap_err", {15'h0, bus.err}, 16'h0);
    check("post_wrap_pc", bus.pc_f, 16'h1004);

    bus.halt = 1'b1;
    #1;
    tick();
    check("halt_hold", bus.pc_f, 16'h1004);
    drive(16'h000E, 1'b0, 1'b0, 1'b0, COND_Z, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0000);
    check("halt_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    bus.halt = 1'b0;
    idle();
    #1;
    check("halt_redirect_pc", bus.pc_f, 16'h0010);

    drive(16'h7FF0, 1'b1, 1'b0, 1'b0, COND_Z, 1'b1, 1'b0, 16'h0020, 16'h0, 16'h7FF2);
    check("ovf_err_pre", {15'h0, bus.err}, 16'h0);
    check("ovf_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    idle();
    #1;
    check("ovf_pc", bus.pc_f, 16'h8012);
    check("ovf_err_set", {15'h0, bus.err}, 16'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("ovf_err_sticky", {15'h0, bus.err}, 16'h1);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_err", {15'h0, bus.err}, 16'h0);
    check("rst2_pc", bus.pc_f, 16'h0000);
    goto(16'h7FF0);
    check("rst2_btb_cleared", bus.pred_next_f, 16'h7FF2);

    drive(16'h0010, 1'b1, 1'b0, 1'b0, COND_LTZ, 1'b0, 1'b1, 16'h0020, 16'h0, 16'h0012);
    check("ltz_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    idle();
    #1;
    check("ltz_pc", bus.pc_f, 16'h0032);
    drive(16'h0030, 1'b1, 1'b0, 1'b0, COND_GEZ, 1'b0, 1'b0, 16'h0020, 16'h0, 16'h0032);
    check("gez_redirect", {15'h0, bus.redirect}, 16'h1);
    tick();
    idle();
    #1;
    check("gez_pc", bus.pc_f, 16'h0052);
    goto(16'h0010);
    check("alias_evicted_pred", bus.pred_next_f, 16'h0012);
    goto(16'h0030);
    check("alias_new_pred", bus.pred_next_f, 16'h0052);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
